// File: rtl/d2l_master_if.sv
// D2L transmit bus: parallel word handshake on the host side, serial
// clock, chip select and the two data lines on the link side.
interface d2l_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  CS;
  logic                  OutLine0;
  logic                  OutLine1;

  modport master (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output sclk,
    output CS,
    output OutLine0,
    output OutLine1
  );

  modport slave (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  sclk,
    input  CS,
    input  OutLine0,
    input  OutLine1
  );
endinterface

// File: rtl/d2l_master.sv
// D2L transmitter: accepts a parallel word and shifts it out MSB first,
// two bits per sclk pulse, framed by one empty pulse before and after.
module d2l_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input logic         clk,
  input logic         rst,
  d2l_master_if.master bus
);

  localparam int PULSES = DATA_WIDTH / 2 + 2;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PC_W   = $clog2(PULSES);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [PC_W-1:0]  PC_LAST      = PC_W'(PULSES - 1);
  localparam logic [PC_W-1:0]  PC_DATA_LAST = PC_W'(DATA_WIDTH / 2);

  typedef enum logic [1:0] {
    IDLE,
    START_TX,
    DATA_TX,
    END_TX
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
  logic [PC_W-1:0]       pulse_cnt_reg, pulse_cnt_next;
  logic                  sclk_reg, sclk_next;
  logic                  cs_reg, cs_next;
  logic                  out1_reg, out1_next;
  logic                  out0_reg, out0_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  ready_reg, ready_next;
  logic                  tick;

  // One tick per sclk half-period; every tick is either an sclk edge or
  // the frame-end slot that follows the final fall.
  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      div_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      sclk_reg      <= 1'b0;
      cs_reg        <= 1'b1;
      out1_reg      <= 1'b0;
      out0_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      div_cnt_reg   <= div_cnt_next;
      pulse_cnt_reg <= pulse_cnt_next;
      sclk_reg      <= sclk_next;
      cs_reg        <= cs_next;
      out1_reg      <= out1_next;
      out0_reg      <= out0_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    div_cnt_next   = div_cnt_reg;
    pulse_cnt_next = pulse_cnt_reg;
    sclk_next      = sclk_reg;
    cs_next        = cs_reg;
    out1_next      = out1_reg;
    out0_next      = out0_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    ready_next     = ready_reg;

    case (state_reg)
      IDLE: begin
        if (bus.tx_valid && ready_reg) begin
          shift_next     = bus.tx_data;
          cs_next        = 1'b0;
          busy_next      = 1'b1;
          ready_next     = 1'b0;
          div_cnt_next   = '0;
          pulse_cnt_next = '0;
          sclk_next      = 1'b0;
          state_next     = START_TX;
        end else begin
          ready_next = 1'b1;
        end
      end

      default: begin
        div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
        if (tick) begin
          if (sclk_reg) begin
            // Falling edge: the slave samples here, so lines are left alone.
            // The state advances to describe the pulse that rises next.
            sclk_next = 1'b0;
            if (pulse_cnt_reg == PC_LAST) begin
              pulse_cnt_next = '0;
            end else begin
              pulse_cnt_next = pulse_cnt_reg + PC_W'(1);
            end
            if (state_reg == START_TX) begin
              state_next = DATA_TX;
            end else if (state_reg == DATA_TX && pulse_cnt_reg == PC_DATA_LAST) begin
              state_next = END_TX;
            end
          end else if (state_reg == END_TX && pulse_cnt_reg == '0) begin
            // Pulse counter has wrapped after the trailing pulse: close the frame.
            state_next   = IDLE;
            cs_next      = 1'b1;
            out1_next    = 1'b0;
            out0_next    = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            ready_next   = 1'b1;
            div_cnt_next = '0;
          end else begin
            sclk_next = 1'b1;
            if (state_reg == DATA_TX) begin
              out1_next  = shift_reg[DATA_WIDTH-1];
              out0_next  = shift_reg[DATA_WIDTH-2];
              shift_next = shift_reg << 2;
            end else begin
              out1_next = 1'b0;
              out0_next = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign bus.tx_ready = ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.sclk     = sclk_reg;
  assign bus.CS       = cs_reg;
  assign bus.OutLine1 = out1_reg;
  assign bus.OutLine0 = out0_reg;

endmodule

// File: tb/tb_d2l_master.sv
// Directed bench for d2l_master: an 8-bit/div-2 link and a 16-bit/div-1 link,
// each watched by a model slave that samples the lines on every sclk fall.
module tb_d2l_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  d2l_master_if #(.DATA_WIDTH(8))  bus8();
  d2l_master_if #(.DATA_WIDTH(16)) bus16();

  d2l_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.master)
  );

  d2l_master #(.DATA_WIDTH(16), .CLK_DIV(1)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.master)
  );

  logic cs_w[2], sclk_w[2], l1_w[2], l0_w[2], done_w[2], ready_w[2], busy_w[2];
  assign cs_w[0]    = bus8.CS;        assign cs_w[1]    = bus16.CS;
  assign sclk_w[0]  = bus8.sclk;      assign sclk_w[1]  = bus16.sclk;
  assign l1_w[0]    = bus8.OutLine1;  assign l1_w[1]    = bus16.OutLine1;
  assign l0_w[0]    = bus8.OutLine0;  assign l0_w[1]    = bus16.OutLine0;
  assign done_w[0]  = bus8.done;      assign done_w[1]  = bus16.done;
  assign ready_w[0] = bus8.tx_ready;  assign ready_w[1] = bus16.tx_ready;
  assign busy_w[0]  = bus8.busy;      assign busy_w[1]  = bus16.busy;

  // Model slave and frame statistics, updated once per clk on the falling edge
  bit          prev_cs[2] = '{1'b1, 1'b1};
  bit          prev_sclk[2];
  int          cs_low_cnt[2], last_cs_low[2], cs_high_cnt[2], last_cs_high[2];
  int          sclk_hi_cnt[2], last_sclk_hi[2], done_cnt[2], pair_n[2];
  bit          last_done_at_rise[2];
  logic [63:0] pair_bits[2] = '{64'd0, 64'd0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i] === 1'b0 && prev_cs[i]) begin
        cs_low_cnt[i]   <= 1;
        sclk_hi_cnt[i]  <= 0;
        last_cs_high[i] <= cs_high_cnt[i];
        cs_high_cnt[i]  <= 0;
      end else if (cs_w[i] === 1'b0) begin
        cs_low_cnt[i] <= cs_low_cnt[i] + 1;
        if (sclk_w[i] === 1'b1) sclk_hi_cnt[i] <= sclk_hi_cnt[i] + 1;
      end else begin
        cs_high_cnt[i] <= cs_high_cnt[i] + 1;
        if (!prev_cs[i]) begin
          last_cs_low[i]       <= cs_low_cnt[i];
          last_sclk_hi[i]      <= sclk_hi_cnt[i];
          last_done_at_rise[i] <= (done_w[i] === 1'b1);
        end
      end
      if (prev_sclk[i] && sclk_w[i] === 1'b0 && cs_w[i] === 1'b0) begin
        pair_bits[i] <= {pair_bits[i][61:0], l1_w[i], l0_w[i]};
        pair_n[i]    <= pair_n[i] + 1;
      end
      if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      prev_cs[i]   <= (cs_w[i] !== 1'b0);
      prev_sclk[i] <= (sclk_w[i] === 1'b1);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit v, input logic [15:0] d);
    if (i == 0) begin
      bus8.tx_valid = v;
      bus8.tx_data  = d[7:0];
    end else begin
      bus16.tx_valid = v;
      bus16.tx_data  = d;
    end
  endtask

  task automatic wait_ready(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ready_w[i] === 1'b1) got = 1'b1;
    end
    chk("ready_wait", {63'd0, got}, 64'd1);
  endtask

  task automatic send(input int i, input logic [15:0] d);
    wait_ready(i);
    drive(i, 1'b1, d);
    @(negedge clk);
    drive(i, 1'b0, d);
  endtask

  task automatic wait_done(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (done_w[i] === 1'b1) got = 1'b1;
    end
    chk("done_wait", {63'd0, got}, 64'd1);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          npairs;
    logic [63:0] pairs;
    int          cs_low;
    int          sclk_hi;
  } vec_t;

  vec_t tbl[6];

  task automatic check_frame(input vec_t v, input int n0, input int d0, input string tag);
    logic [63:0] mask;
    logic [63:0] word;
    int          i;
    i = v.inst;
    repeat (2) @(negedge clk);
    #1;
    mask = (64'd1 << (2 * v.npairs)) - 64'd1;
    word = (pair_bits[i] >> 2) & ((64'd1 << (2 * (v.npairs - 2))) - 64'd1);
    $display("frame %s inst=%0d data=0x%0h pairs=0x%0h cs_low=%0d sclk_hi=%0d",
             tag, i, v.data, pair_bits[i] & mask, last_cs_low[i], last_sclk_hi[i]);
    chk({tag, "_npairs"}, 64'(pair_n[i] - n0), 64'(v.npairs));
    chk({tag, "_pairs"}, pair_bits[i] & mask, v.pairs);
    chk({tag, "_slave_word"}, word, {48'd0, v.data});
    chk({tag, "_cs_low"}, 64'(last_cs_low[i]), 64'(v.cs_low));
    chk({tag, "_sclk_hi"}, 64'(last_sclk_hi[i]), 64'(v.sclk_hi));
    chk({tag, "_done_count"}, 64'(done_cnt[i] - d0), 64'd1);
    chk({tag, "_done_at_cs_rise"}, {63'd0, last_done_at_rise[i]}, 64'd1);
    chk({tag, "_busy_after"}, {63'd0, busy_w[i]}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n0, d0;
    n0 = pair_n[v.inst];
    d0 = done_cnt[v.inst];
    send(v.inst, v.data);
    wait_done(v.inst);
    check_frame(v, n0, d0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, d0;
    bit  got, tog;

    // Framing pulses are 00; the middle pairs are the word, MSB pair first
    tbl[0] = '{0, 16'h00B4, 6,  64'h2D0,   26, 12};  // 00 10 11 01 00 00
    tbl[1] = '{1, 16'hA55A, 10, 64'h29568, 21, 10};  // 00 10 10 01 01 01 01 10 10 00
    tbl[2] = '{0, 16'h005A, 6,  64'h168,   26, 12};  // 00 01 01 10 10 00
    tbl[3] = '{0, 16'h00FF, 6,  64'h3FC,   26, 12};  // 00 11 11 11 11 00
    tbl[4] = '{0, 16'h0000, 6,  64'h000,   26, 12};
    tbl[5] = '{0, 16'h00C3, 6,  64'h30C,   26, 12};  // 00 11 00 00 11 00

    // Reset held with a pending request
    drive(0, 1'b1, 16'h00AA);
    drive(1, 1'b0, 16'h0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", {63'd0, cs_w[0]}, 64'd1);
    chk("rst_sclk", {63'd0, sclk_w[0]}, 64'd0);
    chk("rst_lines", {62'd0, l1_w[0], l0_w[0]}, 64'd0);
    chk("rst_done", {63'd0, done_w[0]}, 64'd0);
    chk("rst_ready", {63'd0, ready_w[0]}, 64'd0);
    chk("rst_busy", {63'd0, busy_w[0]}, 64'd0);
    chk("rst_cs16", {63'd0, cs_w[1]}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, ready_w[0]}, 64'd1);
    chk("post_rst_no_frame", {63'd0, cs_w[0]}, 64'd1);
    @(negedge clk);
    chk("first_accept_cs", {63'd0, cs_w[0]}, 64'd0);
    chk("first_accept_busy", {63'd0, busy_w[0]}, 64'd1);
    drive(0, 1'b0, 16'h0000);
    wait_done(0);
    repeat (3) @(negedge clk);

    for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Back-to-back 0xFF then 0x00 with tx_valid held
    n0 = pair_n[0];
    d0 = done_cnt[0];
    wait_ready(0);
    drive(0, 1'b1, 16'h00FF);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (busy_w[0] === 1'b1) got = 1'b1;
    end
    chk("b2b_first_accept", {63'd0, got}, 64'd1);
    drive(0, 1'b1, 16'h0000);
    wait_done(0);
    @(negedge clk);
    chk("b2b_second_accept_busy", {63'd0, busy_w[0]}, 64'd1);
    chk("b2b_second_accept_cs", {63'd0, cs_w[0]}, 64'd0);
    drive(0, 1'b0, 16'h0000);
    wait_done(0);
    repeat (2) @(negedge clk);
    #1;
    $display("frame b2b inst=0 pairs=0x%0h cs_high_gap=%0d", pair_bits[0] & 64'hFFFFFF, last_cs_high[0]);
    chk("b2b_cs_high_gap", 64'(last_cs_high[0]), 64'd1);
    chk("b2b_npairs", 64'(pair_n[0] - n0), 64'd12);
    chk("b2b_pairs", pair_bits[0] & 64'hFFFFFF, 64'h3FC000);
    chk("b2b_done_count", 64'(done_cnt[0] - d0), 64'd2);
    chk("b2b_cs_low", 64'(last_cs_low[0]), 64'd26);

    // Reset after the third sclk fall of a 0xB4 frame
    n0 = pair_n[0];
    d0 = done_cnt[0];
    send(0, 16'h00B4);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      #1;
      if (pair_n[0] - n0 >= 3) got = 1'b1;
    end
    chk("abort_third_fall", {63'd0, got}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs", {63'd0, cs_w[0]}, 64'd1);
    chk("abort_sclk", {63'd0, sclk_w[0]}, 64'd0);
    chk("abort_lines", {62'd0, l1_w[0], l0_w[0]}, 64'd0);
    chk("abort_busy", {63'd0, busy_w[0]}, 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    $display("frame abort inst=0 falls=%0d dones=%0d", pair_n[0] - n0, done_cnt[0] - d0);
    chk("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
    chk("abort_falls", 64'(pair_n[0] - n0), 64'd3);
    run_vec(tbl[2], "after_abort");

    // tx_valid/tx_data churn while a 0xC3 frame is in flight
    n0 = pair_n[0];
    d0 = done_cnt[0];
    send(0, 16'h00C3);
    got = 1'b0;
    tog = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) begin
        got = 1'b1;
      end else begin
        tog = ~tog;
        drive(0, tog, 16'h003C);
      end
    end
    drive(0, 1'b0, 16'h0000);
    chk("immune_done_seen", {63'd0, got}, 64'd1);
    check_frame(tbl[5], n0, d0, "immune");
    repeat (3) @(negedge clk);
    chk("immune_idle_cs", {63'd0, cs_w[0]}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d2l_master.md
Name: d2l_master

Overview:
- Transmit side of the Dual Data Link (D2L).
- Accepts a parallel word over a valid/ready handshake and serialises it two bits per serial-clock period onto OutLine1/OutLine0.
- Generates the serial clock sclk and the active-low chip select CS.
- Feeds the D2L slave receiver directly. That receiver samples CS and both lines on the falling edge of sclk and walks IDLE -> START_RX -> DATA_RX -> END_RX.

Parameters:
DATA_WIDTH, 8, payload bits per frame; must be even and >= 2
CLK_DIV, 2, clk cycles per sclk half-period; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_WIDTH  word to send; sampled only on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  high when idle and able to accept
busy  output  1  high from the accept edge until CS returns high
done  output  1  one-cycle pulse at end of frame
sclk  output  1  serial clock to slave
CS  output  1  slave select, active low
OutLine0  output  1  serial data, lower bit of each pair
OutLine1  output  1  serial data, upper bit of each pair

Behaviour:
- All outputs are registered.
- Reset values (rst=1 at a clk edge, from any state): state IDLE, CS=1, sclk=0, OutLine0=OutLine1=0, busy=0, done=0, tx_ready=0 during reset, tx_ready=1 in the first cycle after reset deasserts.
- Accept: at a clk edge with tx_valid=1 and tx_ready=1. This is edge 0.
  - Latch tx_data into the shift register.
  - CS<=0, busy<=1, tx_ready<=0, enter START_TX.
  - tx_valid while busy is ignored. tx_data changes after accept have no effect.
- States: IDLE -> START_TX -> DATA_TX -> END_TX -> IDLE.
- Timing, with D = CLK_DIV, W = DATA_WIDTH, P = W/2+2 sclk pulses per frame:
  - Setup: sclk=0 and lines=0 for D cycles after edge 0.
  - Pulse p (p=0..P-1): sclk rises at edge D+2pD and falls at edge 2(p+1)D.
  - Lines update only at the same edge as an sclk rise. They are stable across the following fall, which is when the slave samples.
- Pulse 0 (START_TX): lines=00.
- Pulses 1..W/2 (DATA_TX), MSB first:
  - Pulse k+1 drives OutLine1=data[W-1-2k] and OutLine0=data[W-2-2k].
  - The shift register shifts by 2 per pulse.
- Pulse P-1 (END_TX): lines=00.
- Frame end at edge (W+5)D:
  - CS<=1, sclk stays 0, lines<=0, done<=1 for exactly one cycle, busy<=0, state<=IDLE.
  - tx_ready is high in the following cycle.
- Frame length: CS is low for exactly (W+5)D cycles. Defaults give 26.
- Back-to-back: the earliest next accept is edge (W+5)D+1. CS is therefore high for at least one clk cycle between frames and never glitches within a frame.
- sclk is 0 whenever CS=1 and idles low.
- Reset mid-frame aborts at that edge: CS=1, sclk=0, lines 0, no done pulse, latched word discarded.
- A divider counter (0..D-1) and a pulse counter (0..P-1) wrap cleanly. Both clear on accept and on reset.

Test Plan:
1. Reset: hold rst 3 cycles with tx_valid=1 -> CS=1, sclk=0, lines 0, done=0, tx_ready=0; after release tx_ready=1 and no frame starts until an accept edge with tx_ready=1.
2. W=8, D=2, send 0xB4 -> (OutLine1,OutLine0) sampled at the 6 sclk falls = 00,10,11,01,00,00; CS low exactly 26 cycles; done single pulse at edge 26; a model slave captures 0xB4.
3. Back-to-back: tx_valid held with 0xFF then 0x00 -> second accept exactly 1 cycle after done; CS high exactly 1 cycle between frames; pairs 11,11,11,11 then 00,00,00,00.
4. Reset mid-frame after the 3rd sclk fall of 0xB4 -> next edge CS=1, sclk=0, no done; new frame 0x5A gives data pairs 01,01,10,10.
5. Busy immunity: during a 0xC3 frame, toggle tx_valid and change tx_data to 0x3C each cycle -> transmitted pairs 11,00,00,11; only one done.
6. W=16, D=1, send 0xA55A -> CS low 21 cycles; data pairs 10,10,01,01,01,01,10,10; sclk high/low 1 cycle each.
